// File: rtl/rca_pipe_nb.sv
// Pipelined ripple-carry add/subtract with a valid/ready handshake on both sides.
// Each stage adds one SEG-bit slice, so the carry crosses one slice per clock.
// The "not yet added" operand bits travel down the pipe alongside the partial
// sum, which grows by SEG bits per stage.
module rca_pipe_nb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned STAGES = WIDTH / SEG;

  // Whole pipe moves together; it may advance whenever the last slot is free or drained.
  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned AW = WIDTH - k * SEG;  // operand bits still to be added
    localparam int unsigned SW = (k + 1) * SEG;    // sum bits resolved after this stage

    logic          v_in;
    logic          c_in;
    logic [AW-1:0] a_in;
    logic [AW-1:0] b_in;
    logic [SEG:0]  cy;
    logic [SEG-1:0] seg_s;
    logic [SW-1:0] s_nxt;
    logic          v_q;
    logic          c_q;
    logic [SW-1:0] s_q;

    if (k == 0) begin : g_head
      // Operand conditioning: subtract is x + ~y + 1, carry_in ignored.
      assign v_in  = in_valid;
      assign a_in  = x;
      assign b_in  = sub ? ~y : y;
      assign c_in  = sub | carry_in;
      assign s_nxt = seg_s;
    end else begin : g_link
      assign v_in  = g_stage[k-1].v_q;
      assign a_in  = g_stage[k-1].g_ops.a_q;
      assign b_in  = g_stage[k-1].g_ops.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign s_nxt = {seg_s, g_stage[k-1].s_q};
    end

    // Plain SEG-bit ripple chain over the lowest pending operand slice.
    assign cy[0] = c_in;
    for (genvar i = 0; i < SEG; i++) begin : g_bit
      assign seg_s[i] = a_in[i] ^ b_in[i] ^ cy[i];
      assign cy[i+1]  = (a_in[i] & b_in[i]) | (cy[i] & (a_in[i] ^ b_in[i]));
    end

    // Stage register: valid, carry and partial sum shift together on advance.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= cy[SEG];
        s_q <= s_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [AW-SEG-1:0] a_q;
      logic [AW-SEG-1:0] b_q;

      // Carry the upper, not-yet-added operand slices to the next stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[AW-1:SEG];
          b_q <= b_in[AW-1:SEG];
        end
      end
    end else begin : g_tail
      logic ov_q;

      // Signed overflow: operands agree in sign but the result does not.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ov_q <= 1'b0;
        end else if (adv) begin
          ov_q <= (a_in[SEG-1] == b_in[SEG-1]) && (seg_s[SEG-1] != a_in[SEG-1]);
        end
      end

      assign out_valid = v_q;
      assign sum       = s_q;
      assign carry_out = c_q;
      assign overflow  = ov_q;
    end
  end

endmodule

// File: tb/tb_rca_pipe_nb.sv
// Bench for rca_pipe_nb: three instances (4, 1 and 8 stages) share one stimulus
// stream; each is checked every cycle against a slot-level pipeline model.
module tb_rca_pipe_nb;

  localparam int unsigned W  = 32;
  localparam int unsigned ND = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         carry_in;
  logic         sub;
  logic         out_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;

  logic         rdy     [ND];
  logic         o_valid [ND];
  logic         o_co    [ND];
  logic         o_ov    [ND];
  logic [W-1:0] o_sum   [ND];

  always #5 clk = ~clk;

  rca_pipe_nb #(.WIDTH(W), .SEG(8)) u_seg8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .x(x), .y(y),
    .carry_in(carry_in), .sub(sub), .out_valid(o_valid[0]), .out_ready(out_ready),
    .sum(o_sum[0]), .carry_out(o_co[0]), .overflow(o_ov[0]));

  rca_pipe_nb #(.WIDTH(W), .SEG(32)) u_seg32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .x(x), .y(y),
    .carry_in(carry_in), .sub(sub), .out_valid(o_valid[1]), .out_ready(out_ready),
    .sum(o_sum[1]), .carry_out(o_co[1]), .overflow(o_ov[1]));

  rca_pipe_nb #(.WIDTH(W), .SEG(4)) u_seg4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .x(x), .y(y),
    .carry_in(carry_in), .sub(sub), .out_valid(o_valid[2]), .out_ready(out_ready),
    .sum(o_sum[2]), .carry_out(o_co[2]), .overflow(o_ov[2]));

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic int stg(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference result {overflow, carry_out, sum} from plain WIDTH+1-bit arithmetic.
  function automatic logic [W+1:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic ci, input logic sb);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         ov;
    be = sb ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + (W+1)'(sb ? 1'b1 : ci);
    ov = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    return {ov, r};
  endfunction

  // Model: STAGES slots per instance, all shifting when the last slot is empty or consumed.
  bit           m_v [ND][8];
  logic [W+1:0] m_r [ND][8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < ND; d++)
        for (int k = 0; k < 8; k++) begin
          m_v[d][k] <= 1'b0;
          m_r[d][k] <= '0;
        end
    end else begin
      for (int d = 0; d < ND; d++)
        if (out_ready || !m_v[d][stg(d)-1]) begin
          for (int k = 1; k < 8; k++)
            if (k < stg(d)) begin
              m_v[d][k] <= m_v[d][k-1];
              m_r[d][k] <= m_r[d][k-1];
            end
          m_v[d][0] <= in_valid;
          m_r[d][0] <= ref_calc(x, y, carry_in, sub);
        end
    end
  end

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("in_ready[%0d]", d), 64'(rdy[d]), 64'(out_ready || !m_v[d][stg(d)-1]));
        chk($sformatf("out_valid[%0d]", d), 64'(o_valid[d]), 64'(m_v[d][stg(d)-1]));
        if (m_v[d][stg(d)-1])
          chk($sformatf("result[%0d]", d), 64'({o_ov[d], o_co[d], o_sum[d]}), 64'(m_r[d][stg(d)-1]));
      end
    end
  end

  // Results actually transferred out of the 4-stage instance, in order.
  logic [W+1:0] got[$];
  always @(negedge clk) begin
    if (!rst && o_valid[0] && out_ready) got.push_back({o_ov[0], o_co[0], o_sum[0]});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
    in_valid = 1'b1;
    x        = a;
    y        = b;
    carry_in = ci;
    sub      = sb;
    cyc();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int unsigned i;
    int unsigned cnt;
    bit          acc;
    bit          saw_full;
    logic [4:0]  pat;
    logic [9:0]  obs;
    logic [9:0]  expv;

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_out_valid", 64'(o_valid[0]), 64'd0);
    chk("reset_sum", 64'(o_sum[0]), 64'd0);
    chk("reset_carry_out", 64'(o_co[0]), 64'd0);
    chk("reset_overflow", 64'(o_ov[0]), 64'd0);
    chk("reset_in_ready", 64'(rdy[0]), 64'd1);
    cyc();

    // Carry across every segment, back-to-back.
    got.delete();
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
    idle(8);
    chk("carry_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("carry_res0", 64'(got[0]), 64'({1'b0, 1'b1, 32'h0000_0000}));
      chk("carry_res1", 64'(got[1]), 64'({1'b0, 1'b1, 32'h0000_0001}));
    end

    // Subtract and signed overflow.
    got.delete();
    send(32'h5, 32'h7, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h1, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    idle(8);
    chk("sub_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("sub_5_minus_7", 64'(got[0]), 64'({1'b0, 1'b0, 32'hFFFF_FFFE}));
      chk("sub_min_minus_1", 64'(got[1]), 64'({1'b1, 1'b1, 32'h7FFF_FFFF}));
      chk("add_max_plus_1", 64'(got[2]), 64'({1'b1, 1'b0, 32'h8000_0000}));
    end

    // Stall: downstream blocked for cycles 2..7 while six adds stream in.
    got.delete();
    i = 0; cnt = 0; saw_full = 1'b0;
    while (i < 6 && cnt < 60) begin
      in_valid = 1'b1; x = W'(i); y = W'(i); carry_in = 1'b0; sub = 1'b0;
      out_ready = !(cnt >= 2 && cnt <= 7);
      #1;
      acc = rdy[0];
      if (!acc) saw_full = 1'b1;
      @(posedge clk); #1;
      if (acc) i++;
      cnt++;
    end
    chk("stall_all_accepted", 64'(i), 64'd6);
    out_ready = 1'b1;
    idle(8);
    chk("stall_full_seen", 64'(saw_full), 64'd1);
    chk("stall_count", 64'(got.size()), 64'd6);
    if (got.size() == 6)
      for (int j = 0; j < 6; j++)
        chk($sformatf("stall_res%0d", j), 64'(got[j]), 64'({2'b00, W'(2 * j)}));

    // Bubbles: valid pattern 1,0,1,1,0 reappears four cycles later.
    pat = 5'b01101;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 5) ? pat[c] : 1'b0;
      x = W'($urandom); y = W'($urandom); carry_in = 1'($urandom_range(1)); sub = 1'b0;
      #1;
      obs[c] = o_valid[0];
      cyc();
    end
    for (int c = 0; c < 10; c++) expv[c] = (c >= 4 && c < 9) ? pat[c-4] : 1'b0;
    chk("bubble_pattern", 64'(obs), 64'(expv));

    // Random traffic with random back-pressure.
    repeat (10000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      x = pick(); y = pick();
      carry_in = 1'($urandom_range(1));
      sub      = 1'($urandom_range(1));
      cyc();
    end
    out_ready = 1'b1;
    idle(12);

    // Reset with three results in flight.
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);
    send(32'h9, 32'h3, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(o_valid[0]), 64'd0);
    chk("midrst_sum", 64'(o_sum[0]), 64'd0);
    chk("midrst_in_ready", 64'(rdy[0]), 64'd1);
    chk("midrst_out_valid8", 64'(o_valid[2]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    got.delete();
    idle(8);
    chk("midrst_no_stale", 64'(got.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rca_pipe_nb.md
Name: rca_pipe_nb

Overview:
- Parametrised, pipelined successor to the team's 8-bit ripple-carry adder.
- Splits a WIDTH-bit add or subtract into WIDTH/SEG ripple segments, one registered segment per pipeline stage. The carry ripples stage-to-stage, so clock rate no longer depends on full carry-chain length.
- Valid/ready handshake on both sides, so it drops into streaming datapaths (ALU back-end, accumulators) with back-pressure.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG.
- SEG, 8, bits added per pipeline stage; STAGES = WIDTH/SEG (1..64).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  x/y/carry_in/sub are valid this cycle
- in_ready  out  1  block accepts the input this cycle
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- carry_in  in  1  carry into bit 0 (add mode only)
- sub  in  1  0 = add, 1 = subtract (x - y)
- out_valid  out  1  sum/carry_out/overflow valid
- out_ready  in  1  downstream accepts the result this cycle
- sum  out  WIDTH  result, mod 2^WIDTH
- carry_out  out  1  carry out of bit WIDTH-1 (subtract: 1 = no borrow)
- overflow  out  1  two's-complement signed overflow

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset rst is asynchronous and active-high.
- Reset values:
  - All stage valid bits, out_valid, sum, carry_out and overflow are 0.
  - All internal operand and partial-sum registers are 0.
  - in_ready is 1 after reset, since the pipe is empty.
- Arithmetic:
  - Effective B = sub ? ~y : y.
  - Effective cin = sub ? 1 : carry_in; carry_in is ignored when sub=1.
  - {carry_out, sum} = x + B + cin, computed over WIDTH+1 bits.
  - overflow = (x[MSB] == B[MSB]) && (sum[MSB] != x[MSB]).
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] of x and B with the carry registered by stage k-1. Stage 0 uses cin.
  - Stage k registers its SEG sum bits, its carry, and the not-yet-added upper operand bits.
  - Lower sum bits already computed are carried forward unchanged.
  - Each stage's logic is a plain SEG-bit ripple chain, with no lookahead.
  - Outputs are the registers of the last stage.
- Latency and throughput:
  - An input accepted at edge N appears with out_valid=1 immediately after edge N+STAGES-1, i.e. STAGES cycles counting the accept edge.
  - Throughput is one result per cycle when not stalled.
- Handshake:
  - Global advance enable: adv = out_ready || !out_valid; in_ready = adv.
  - in_ready is combinational from out_ready and out_valid only, never from in_valid.
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - When adv=1, every stage (data and valid) shifts one position. Stage 0's valid loads in_valid.
  - When adv=0, all stages hold, including bubbles. While stalled, out_valid, sum, carry_out and overflow stay stable.
  - Bubbles (valid=0) propagate and never assert out_valid. Data registers may update on bubbles, but outputs are only meaningful while out_valid=1.
- Boundary conditions:
  - Simultaneous output consume and input accept in the same cycle is legal; full-rate streaming has no gap.
  - Pipe full with out_ready=0: in_ready=0 and inputs are ignored regardless of in_valid.
  - Reset mid-operation: all in-flight results are discarded immediately (asynchronous). No partial result is ever presented after reset is released.
  - Wrap-around: sum wraps mod 2^WIDTH; carry_out captures the lost bit.
  - STAGES=1: the block degenerates to a registered single-cycle adder with the same handshake.

Test Plan (WIDTH=32, SEG=8, latency 4):
- Reset: assert rst mid-stream with 3 results in flight, then release -> out_valid=0, sum=0, in_ready=1; no stale result emerges in the following 8 cycles.
- Carry across all segments: x=0xFFFFFFFF, y=0x00000001, carry_in=0, then carry_in=1 the next cycle -> results arrive on consecutive cycles: sum=0x00000000 carry_out=1, then sum=0x00000001 carry_out=1.
- Subtract and overflow:
  - x=0x00000005, y=0x00000007, sub=1 -> sum=0xFFFFFFFE, carry_out=0, overflow=0.
  - x=0x80000000, y=0x00000001, sub=1 -> sum=0x7FFFFFFF, carry_out=1, overflow=1.
  - Add x=0x7FFFFFFF, y=0x00000001 -> sum=0x80000000, overflow=1.
- Stall: stream 6 back-to-back adds (x=i, y=i) with out_ready=0 from cycle 2 to cycle 7 -> outputs hold stable, in_ready=0 while full, results 0,2,4,6,8,10 emerge in order with none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,1,0 with out_ready=1 -> out_valid pattern 1,0,1,1,0, delayed exactly 4 cycles.
- Random: 10,000 random x, y, carry_in, sub values with random in_valid/out_ready, checked against a WIDTH+1-bit reference model; repeat with SEG=32 (STAGES=1) and SEG=4 (STAGES=8).
